// File: rtl/frame_commutator.sv
// frame_commutator: per-slot word commutator that replaces the local-channel
// stream with a group of RAM words on the last slot of every frame.
module frame_commutator #(
  parameter int DW        = 8,
  parameter int AW        = 7,
  parameter int GROUP     = 4,
  parameter int NGROUPS   = 32,
  parameter int FRAME_LEN = 128,
  parameter int PAUSE_CYC = 31,
  parameter int GAP_CYC   = 12
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req,
  input  logic                         ins_en,
  input  logic [DW-1:0]                data_ram,
  input  logic [DW-1:0]                data_lcs,
  output logic [DW-1:0]                data_tx,
  output logic [AW-1:0]                addr_ram,
  output logic                         ins_active,
  output logic                         frame_sync,
  output logic [$clog2(FRAME_LEN)-1:0] slot_cnt
);

  localparam int SW   = $clog2(FRAME_LEN);
  localparam int WW   = (GROUP > 1) ? $clog2(GROUP) : 1;
  localparam int GW   = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;
  localparam int MAXC = (PAUSE_CYC > GAP_CYC) ? PAUSE_CYC : GAP_CYC;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [2:0] {IDLE, PAUSE, CHECK, GAP, WAIT} state_t;

  state_t          r_state, w_state_nxt;
  logic            r_req_s1, r_req_s2;
  logic [SW-1:0]   r_slot, w_slot_nxt;
  logic [WW-1:0]   r_word, w_word_nxt;
  logic [GW-1:0]   r_grp, w_grp_nxt;
  logic [AW-1:0]   r_addr, w_addr_nxt;
  logic            r_ins, w_ins_nxt;
  logic            r_sync, w_sync_nxt;
  logic            r_busy, w_busy_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [AW-1:0]   w_addr;

  assign w_addr     = AW'(r_grp) * AW'(GROUP) + AW'(r_word);
  assign data_tx    = r_ins ? data_ram : data_lcs;
  assign addr_ram   = r_addr;
  assign ins_active = r_ins;
  assign frame_sync = r_sync;
  assign slot_cnt   = r_slot;

  // Two-flop synchroniser for the asynchronous request level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_req_s1 <= 1'b0;
      r_req_s2 <= 1'b0;
    end else begin
      r_req_s1 <= req;
      r_req_s2 <= r_req_s1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_slot  <= '0;
      r_word  <= '0;
      r_grp   <= '0;
      r_addr  <= '0;
      r_ins   <= 1'b0;
      r_sync  <= 1'b0;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_slot  <= w_slot_nxt;
      r_word  <= w_word_nxt;
      r_grp   <= w_grp_nxt;
      r_addr  <= w_addr_nxt;
      r_ins   <= w_ins_nxt;
      r_sync  <= w_sync_nxt;
      r_busy  <= w_busy_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state and next-value logic; r_busy marks CHECKs re-entered from GAP
  // so frame_sync and the ins_en sample happen only on the first one.
  always_comb begin
    w_state_nxt = r_state;
    w_slot_nxt  = r_slot;
    w_word_nxt  = r_word;
    w_grp_nxt   = r_grp;
    w_addr_nxt  = r_addr;
    w_ins_nxt   = r_ins;
    w_sync_nxt  = 1'b0;
    w_busy_nxt  = r_busy;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (r_req_s2) begin
          w_slot_nxt  = (r_slot == SW'(FRAME_LEN - 1)) ? '0 : r_slot + 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = PAUSE;
        end
      end
      PAUSE: begin
        if (r_cnt == CW'(PAUSE_CYC - 1)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = CHECK;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      CHECK: begin
        if (r_slot != SW'(FRAME_LEN - 1)) begin
          w_state_nxt = WAIT;
        end else begin
          if (!r_busy) w_sync_nxt = 1'b1;
          if (r_busy || ins_en) begin
            w_ins_nxt  = 1'b1;
            w_addr_nxt = w_addr;
            if (r_word != WW'(GROUP - 1)) begin
              w_word_nxt  = r_word + 1'b1;
              w_busy_nxt  = 1'b1;
              w_cnt_nxt   = '0;
              w_state_nxt = GAP;
            end else begin
              w_word_nxt  = '0;
              w_grp_nxt   = (r_grp == GW'(NGROUPS - 1)) ? '0 : r_grp + 1'b1;
              w_busy_nxt  = 1'b0;
              w_state_nxt = WAIT;
            end
          end else begin
            w_state_nxt = WAIT;
          end
        end
      end
      GAP: begin
        if (r_cnt == CW'(GAP_CYC - 1)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = CHECK;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      WAIT: begin
        if (!r_req_s2) begin
          w_ins_nxt   = 1'b0;
          w_addr_nxt  = '0;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_frame_commutator.sv
// Directed scoreboard bench for frame_commutator.
module tb_frame_commutator;

  localparam int P  = 4;
  localparam int G  = 12;
  localparam int GR = 4;
  localparam int NG = 32;
  localparam int FL = 128;

  logic       clk = 1'b0;
  logic       rst, req, ins_en;
  logic [7:0] data_ram, data_lcs, data_tx;
  logic [6:0] addr_ram;
  logic       ins_active, frame_sync;
  logic [6:0] slot_cnt;

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;
  int unsigned m_slot, m_grp;
  int unsigned q[$];

  frame_commutator #(
    .DW(8), .AW(7), .GROUP(GR), .NGROUPS(NG), .FRAME_LEN(FL),
    .PAUSE_CYC(P), .GAP_CYC(G)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .ins_en(ins_en),
    .data_ram(data_ram), .data_lcs(data_lcs), .data_tx(data_tx),
    .addr_ram(addr_ram), .ins_active(ins_active), .frame_sync(frame_sync),
    .slot_cnt(slot_cnt)
  );

  always #5 clk = ~clk;

  // RAM model: contents derived from the address.
  assign data_ram = {1'b0, addr_ram} ^ 8'hC3;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_frame(input bit drop_en, input bit do_rst);
    int unsigned exp_a;
    bit ins, sync;
    m_slot = (m_slot + 1) % FL;
    sync   = (m_slot == FL - 1);
    ins    = sync && ins_en;
    if (ins) begin
      for (int unsigned w = 0; w < GR; w++) q.push_back(m_grp * GR + w);
      m_grp = (m_grp + 1) % NG;
    end
    data_lcs = 8'($urandom);
    req = 1'b1;
    tick;
    if (!ins) req = 1'b0;
    tick;
    tick;
    chk("slot_cnt", slot_cnt, m_slot);
    for (int i = 0; i < P; i++) tick;
    chk("pause_ins", ins_active, 0);
    chk("pause_sync", frame_sync, 0);
    tick;
    chk("frame_sync", frame_sync, sync);
    chk("ins_active", ins_active, ins);
    if (!ins) begin
      chk("data_lcs", data_tx, data_lcs);
      tick;
      chk("sync_off", frame_sync, 0);
      return;
    end
    exp_a = 0;
    for (int w = 0; w < GR; w++) begin
      exp_a = q.pop_front();
      for (int c = 0; c <= G; c++) begin
        if (c > 0 || w > 0) tick;
        chk("addr_ram", addr_ram, exp_a);
        chk("ins_hold", ins_active, 1);
        chk("data_ram", data_tx, 8'(exp_a) ^ 8'hC3);
        if (w == 0 && c == 1) chk("sync_pulse", frame_sync, 0);
        if (drop_en && w == 1 && c == 3) ins_en = 1'b0;
        if (do_rst && w == 1 && c == 5) begin
          rst = 1'b0;
          req = 1'b0;
          #1;
          chk("rst_addr", addr_ram, 0);
          chk("rst_ins", ins_active, 0);
          chk("rst_slot", slot_cnt, 0);
          chk("rst_tx", data_tx, data_lcs);
          tick;
          chk("rst_addr_nx", addr_ram, 0);
          chk("rst_ins_nx", ins_active, 0);
          rst = 1'b1;
          m_slot = 0;
          m_grp  = 0;
          q.delete();
          return;
        end
      end
    end
    req = 1'b0;
    tick;
    tick;
    chk("last_hold", addr_ram, exp_a);
    chk("last_ins", ins_active, 1);
    tick;
    chk("wait_addr", addr_ram, 0);
    chk("wait_ins", ins_active, 0);
    chk("wait_tx", data_tx, data_lcs);
  endtask

  initial begin
    rst      = 1'b0;
    req      = 1'b0;
    ins_en   = 1'b0;
    data_lcs = 8'h5A;
    #1;
    chk("rst_data_tx", data_tx, 8'h5A);
    chk("rst_addr0", addr_ram, 0);
    chk("rst_ins0", ins_active, 0);
    chk("rst_slot0", slot_cnt, 0);
    chk("rst_sync0", frame_sync, 0);
    @(negedge clk);
    @(negedge clk);
    rst    = 1'b1;
    ins_en = 1'b1;
    m_slot = 0;
    m_grp  = 0;

    // 33 insertion frames: groups 0..31, then wrap to group 0.
    repeat (33 * FL - 1) run_frame(1'b0, 1'b0);

    // Insertion disabled at the sync slot: pulse only, group kept.
    repeat (FL - 1) run_frame(1'b0, 1'b0);
    ins_en = 1'b0;
    run_frame(1'b0, 1'b0);
    ins_en = 1'b1;

    // Enable dropped mid-insertion: the group still completes.
    repeat (FL - 1) run_frame(1'b0, 1'b0);
    run_frame(1'b1, 1'b0);
    ins_en = 1'b1;

    // Reset in GAP, then the next insertion restarts at address 0.
    repeat (FL - 1) run_frame(1'b0, 1'b0);
    run_frame(1'b0, 1'b1);
    ins_en = 1'b1;
    repeat (FL - 1) run_frame(1'b0, 1'b0);
    chk("queue_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

  initial begin
    #5000000;
    n_err++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $fatal(1, "watchdog");
  end

endmodule
